// File: rtl/jpeg_ctrl_pkg.sv
// Shared types and protocol constants for the JPEG frame sequencer.
// FRAME_CSUM_EN adds the STATUS_CSUM state for the trailing checksum byte.
package jpeg_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LOAD,
        PAD,
        WAIT_EOI,
        STATUS
`ifdef FRAME_CSUM_EN
        ,
        STATUS_CSUM
`endif
    } state_t;

    localparam logic [7:0] CMD_ENCODE = 8'h01;
    localparam logic [7:0] CMD_PING   = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_PAD     = 8'hE1;
    localparam logic [7:0] ST_PING    = 8'h55;
    localparam logic [7:0] ST_BADCMD  = 8'hEE;

    localparam logic [7:0] EOI_B0     = 8'hFF;
    localparam logic [7:0] EOI_B1     = 8'hD9;

endpackage

// File: rtl/jpeg_frame_ctrl_eoi_detect.sv
// Spots the JPEG EOI marker (FF followed by D9) in the coder output byte stream.
// Only consecutive accepted bytes form a pair; idle cycles between them do not matter.
module eoi_detect
    import jpeg_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enc_valid,
    input  logic [7:0] enc_data,
    output logic       eoi
);

    logic ff_seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ff_seen <= 1'b0;
        else if (clear)
            ff_seen <= 1'b0;
        else if (enc_valid)
            ff_seen <= (enc_data == EOI_B0);
    end

    assign eoi = enc_valid && ff_seen && (enc_data == EOI_B1);

endmodule

// File: rtl/jpeg_frame_ctrl.sv
// Frame sequencer: parses host commands, gates WIDTH*HEIGHT pixels into the coder,
// pads stalled frames, waits for EOI and returns a status byte. Option: FRAME_CSUM_EN.
module jpeg_frame_ctrl
    import jpeg_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH       = 512,
    parameter int unsigned HEIGHT      = 512,
    parameter int unsigned TIMEOUT_CYC = 5000000,
    parameter int unsigned PAD_GAP     = 16,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       px_valid,
    output logic [7:0] px_data,
    input  logic       enc_valid,
    input  logic [7:0] enc_data,
    output logic       sts_valid,
    output logic [7:0] sts_data,
    input  logic       sts_ready,
    output logic       busy,
    output logic       overrun
);

    localparam int unsigned TOTAL = WIDTH * HEIGHT;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned IW    = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned PW    = $clog2(PAD_GAP + 1);

    state_t          state, state_n;
    logic [CW-1:0]   pix_cnt, pix_n;
    logic [IW-1:0]   idle_cnt, idle_n;
    logic [PW-1:0]   gap_cnt, gap_n;
    logic            err, err_n;
    logic            px_valid_n;
    logic [7:0]      px_data_n;
    logic            sts_valid_n;
    logic [7:0]      sts_data_n;
    logic            overrun_n;
    logic            eoi_clear;
    logic            eoi;
`ifdef FRAME_CSUM_EN
    logic [7:0]      csum, csum_n;
    logic            csum_pend, csum_pend_n;
`endif

    eoi_detect u_eoi (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (eoi_clear),
        .enc_valid (enc_valid),
        .enc_data  (enc_data),
        .eoi       (eoi)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pix_cnt   <= '0;
            idle_cnt  <= '0;
            gap_cnt   <= '0;
            err       <= 1'b0;
            px_valid  <= 1'b0;
            px_data   <= 8'h00;
            sts_valid <= 1'b0;
            sts_data  <= 8'h00;
            overrun   <= 1'b0;
`ifdef FRAME_CSUM_EN
            csum      <= 8'h00;
            csum_pend <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            pix_cnt   <= pix_n;
            idle_cnt  <= idle_n;
            gap_cnt   <= gap_n;
            err       <= err_n;
            px_valid  <= px_valid_n;
            px_data   <= px_data_n;
            sts_valid <= sts_valid_n;
            sts_data  <= sts_data_n;
            overrun   <= overrun_n;
`ifdef FRAME_CSUM_EN
            csum      <= csum_n;
            csum_pend <= csum_pend_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        pix_n       = pix_cnt;
        idle_n      = idle_cnt;
        gap_n       = gap_cnt;
        err_n       = err;
        px_valid_n  = 1'b0;
        px_data_n   = 8'h00;
        sts_valid_n = sts_valid;
        sts_data_n  = sts_data;
        overrun_n   = overrun;
        eoi_clear   = 1'b0;
`ifdef FRAME_CSUM_EN
        csum_n      = csum;
        csum_pend_n = csum_pend;
`endif

        case (state)
            IDLE: begin
                if (rx_valid && rx_data == SYNC_BYTE)
                    state_n = CMD;
            end

            CMD: begin
                if (rx_valid) begin
                    if (rx_data == CMD_ENCODE) begin
                        state_n = LOAD;
                        pix_n   = '0;
                        idle_n  = '0;
                        err_n   = 1'b0;
`ifdef FRAME_CSUM_EN
                        csum_n  = 8'h00;
`endif
                    end else begin
                        state_n     = STATUS;
                        sts_valid_n = 1'b1;
                        sts_data_n  = (rx_data == CMD_PING) ? ST_PING : ST_BADCMD;
`ifdef FRAME_CSUM_EN
                        csum_pend_n = 1'b0;
`endif
                    end
                end
            end

            // A byte arriving on the timeout cycle wins over the timeout.
            LOAD: begin
                if (rx_valid) begin
                    px_valid_n = 1'b1;
                    px_data_n  = rx_data;
                    pix_n      = pix_cnt + CW'(1);
                    idle_n     = '0;
`ifdef FRAME_CSUM_EN
                    csum_n     = csum + rx_data;
`endif
                    if (pix_n == CW'(TOTAL)) begin
                        state_n   = WAIT_EOI;
                        eoi_clear = 1'b1;
                    end
                end else begin
                    if (idle_cnt != IW'(TIMEOUT_CYC))
                        idle_n = idle_cnt + IW'(1);
                    if (idle_n == IW'(TIMEOUT_CYC)) begin
                        state_n = PAD;
                        err_n   = 1'b1;
                        gap_n   = '0;
                    end
                end
            end

            PAD: begin
                if (gap_cnt == PW'(PAD_GAP - 1)) begin
                    gap_n      = '0;
                    px_valid_n = 1'b1;
                    pix_n      = pix_cnt + CW'(1);
                    if (pix_n == CW'(TOTAL)) begin
                        state_n   = WAIT_EOI;
                        eoi_clear = 1'b1;
                    end
                end else begin
                    gap_n = gap_cnt + PW'(1);
                end
            end

            WAIT_EOI: begin
                if (rx_valid)
                    overrun_n = 1'b1;
                if (eoi) begin
                    state_n     = STATUS;
                    sts_valid_n = 1'b1;
                    sts_data_n  = err ? ST_PAD : ST_OK;
`ifdef FRAME_CSUM_EN
                    csum_pend_n = 1'b1;
`endif
                end
            end

            STATUS: begin
                if (rx_valid)
                    overrun_n = 1'b1;
                if (sts_ready) begin
`ifdef FRAME_CSUM_EN
                    if (csum_pend) begin
                        state_n     = STATUS_CSUM;
                        sts_data_n  = csum;
                        csum_pend_n = 1'b0;
                    end else begin
                        state_n     = IDLE;
                        sts_valid_n = 1'b0;
                    end
`else
                    state_n     = IDLE;
                    sts_valid_n = 1'b0;
`endif
                end
            end

`ifdef FRAME_CSUM_EN
            STATUS_CSUM: begin
                if (rx_valid)
                    overrun_n = 1'b1;
                if (sts_ready) begin
                    state_n     = IDLE;
                    sts_valid_n = 1'b0;
                end
            end
`endif

            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE) && (state != CMD);

endmodule

// File: tb/tb_jpeg_frame_ctrl.sv
// Directed self-checking bench for jpeg_frame_ctrl at a 4x4 frame with short timeouts.
// Expects the trailing checksum byte when built with FRAME_CSUM_EN.
module tb_jpeg_frame_ctrl;

    localparam int TO  = 100;
    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       px_valid;
    logic [7:0] px_data;
    logic       enc_valid = 1'b0;
    logic [7:0] enc_data = 8'h00;
    logic       sts_valid;
    logic [7:0] sts_data;
    logic       sts_ready = 1'b0;
    logic       busy;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] px_q[$];
    int         pxc_q[$];

    jpeg_frame_ctrl #(
        .WIDTH(4), .HEIGHT(4), .TIMEOUT_CYC(TO), .PAD_GAP(GAP), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .px_valid(px_valid), .px_data(px_data),
        .enc_valid(enc_valid), .enc_data(enc_data),
        .sts_valid(sts_valid), .sts_data(sts_data), .sts_ready(sts_ready),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Every pixel strobe is logged with the cycle it was visible in.
    always @(negedge clk) begin
        if (px_valid === 1'b1) begin
            px_q.push_back(px_data);
            pxc_q.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_rx(input logic [7:0] b, output int c);
        c        = cyc;
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_enc(input logic [7:0] b);
        enc_valid = 1'b1;
        enc_data  = b;
        tick(1);
        enc_valid = 1'b0;
        enc_data  = 8'h00;
    endtask

    task automatic take_status(output logic seen, output logic [7:0] data);
        int n = 0;
        seen = 1'b0;
        data = 8'h00;
        while (sts_valid !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        if (sts_valid === 1'b1) begin
            seen      = 1'b1;
            data      = sts_data;
            sts_ready = 1'b1;
            tick(1);
            sts_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [12:0] got;
        got = {px_valid, px_data, sts_valid, busy, overrun, |sts_data};
        checks++;
        if (got !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %0h expected 0", got);
        end
    endtask

    task automatic test_frame();
        logic [7:0] d[16];
        int         rxc[16];
        int         c;
        logic       seen;
        logic [7:0] sd;
        logic [7:0] sum = 8'h00;
        px_q.delete();
        pxc_q.delete();
        send_rx(8'hA5, c);
        send_rx(8'h01, c);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_busy: got %b expected 1", busy);
        end
        for (int i = 0; i < 16; i++) begin
            d[i] = 8'(i * 13 + 7);
            sum  = sum + d[i];
            send_rx(d[i], rxc[i]);
        end
        tick(1);
        checks++;
        if (px_q.size() != 16) begin
            errors++;
            $display("[TB] FAIL frame_px_count: got %0d expected 16", px_q.size());
        end
        for (int i = 0; i < 16 && i < px_q.size(); i++) begin
            checks++;
            if (px_q[i] !== d[i] || pxc_q[i] != rxc[i] + 1) begin
                errors++;
                $display("[TB] FAIL frame_px[%0d]: got %0h@%0d expected %0h@%0d",
                         i, px_q[i], pxc_q[i], d[i], rxc[i] + 1);
            end
        end
        send_enc(8'h12);
        send_enc(8'hFF);
        send_enc(8'hD9);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (sts_valid !== 1'b1 || sts_data !== 8'h00) begin
                errors++;
                $display("[TB] FAIL frame_status_hold[%0d]: got %b/%0h expected 1/0", k, sts_valid, sts_data);
            end
            tick(1);
        end
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL frame_status: got %b/%0h expected 1/0", seen, sd);
        end
`ifdef FRAME_CSUM_EN
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== sum) begin
            errors++;
            $display("[TB] FAIL frame_csum: got %b/%0h expected 1/%0h", seen, sd, sum);
        end
`endif
        checks++;
        if (sts_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_done: got sts_valid=%b busy=%b expected 0/0", sts_valid, busy);
        end
    endtask

    task automatic test_pad();
        logic [7:0] d[10];
        int         c;
        int         n;
        logic       seen;
        logic [7:0] sd;
        logic [7:0] sum = 8'h00;
        px_q.delete();
        pxc_q.delete();
        send_rx(8'hA5, c);
        send_rx(8'h01, c);
        for (int i = 0; i < 10; i++) begin
            d[i] = 8'(8'hF0 - i * 9);
            sum  = sum + d[i];
            send_rx(d[i], c);
        end
        n = 0;
        while (px_q.size() < 12 && n < 400) begin
            tick(1);
            n++;
        end
        send_rx(8'h77, c);
        n = 0;
        while (px_q.size() < 16 && n < 400) begin
            tick(1);
            n++;
        end
        tick(12);
        checks++;
        if (px_q.size() != 16) begin
            errors++;
            $display("[TB] FAIL pad_px_count: got %0d expected 16", px_q.size());
        end
        checks++;
        if (px_q.size() >= 11 && pxc_q[10] - pxc_q[9] != TO + GAP) begin
            errors++;
            $display("[TB] FAIL pad_first_latency: got %0d expected %0d", pxc_q[10] - pxc_q[9], TO + GAP);
        end
        for (int k = 10; k < 16 && k < px_q.size(); k++) begin
            checks++;
            if (px_q[k] !== 8'h00 || (k > 10 && pxc_q[k] - pxc_q[k-1] != GAP)) begin
                errors++;
                $display("[TB] FAIL pad_byte[%0d]: got %0h spacing %0d expected 0 spacing %0d",
                         k, px_q[k], pxc_q[k] - pxc_q[k-1], GAP);
            end
        end
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1 || sts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pad_flags: got overrun=%b busy=%b sts_valid=%b expected 0/1/0",
                     overrun, busy, sts_valid);
        end
        send_enc(8'hFF);
        send_enc(8'hD9);
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'hE1) begin
            errors++;
            $display("[TB] FAIL pad_status: got %b/%0h expected 1/e1", seen, sd);
        end
`ifdef FRAME_CSUM_EN
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== sum) begin
            errors++;
            $display("[TB] FAIL pad_csum: got %b/%0h expected 1/%0h", seen, sd, sum);
        end
`endif
    endtask

    task automatic test_ping();
        int         c;
        logic       seen;
        logic [7:0] sd;
        px_q.delete();
        pxc_q.delete();
        send_rx(8'h3C, c);
        send_rx(8'hA5, c);
        send_rx(8'h02, c);
        checks++;
        if (busy !== 1'b1 || sts_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ping_pending: got busy=%b sts_valid=%b expected 1/1", busy, sts_valid);
        end
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'h55 || sts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ping_status: got %b/%0h after=%b expected 1/55 after=0", seen, sd, sts_valid);
        end
        send_rx(8'hA5, c);
        send_rx(8'h7F, c);
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'hEE || sts_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL badcmd_status: got %b/%0h after=%b busy=%b expected 1/ee after=0 busy=0",
                     seen, sd, sts_valid, busy);
        end
        checks++;
        if (px_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL ping_no_px: got %0d expected 0", px_q.size());
        end
    endtask

    task automatic test_eoi_overrun();
        int         c;
        logic       seen;
        logic [7:0] sd;
        px_q.delete();
        pxc_q.delete();
        send_rx(8'hA5, c);
        send_rx(8'h01, c);
        for (int i = 1; i <= 15; i++)
            send_rx(8'(i), c);
        send_enc(8'hFF);
        send_rx(8'd16, c);
        send_enc(8'hD9);
        tick(3);
        checks++;
        if (sts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eoi_straddle: got sts_valid=%b expected 0", sts_valid);
        end
        send_enc(8'hFF);
        send_enc(8'h00);
        send_enc(8'hD9);
        tick(3);
        checks++;
        if (sts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL eoi_broken_pair: got sts_valid=%b expected 0", sts_valid);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got %b expected 0", overrun);
        end
        send_rx(8'h33, c);
        checks++;
        if (overrun !== 1'b1 || px_q.size() != 16) begin
            errors++;
            $display("[TB] FAIL overrun_set: got overrun=%b px=%0d expected 1/16", overrun, px_q.size());
        end
        send_enc(8'hFF);
        tick(2);
        send_enc(8'hD9);
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL eoi_gap_status: got %b/%0h expected 1/0", seen, sd);
        end
`ifdef FRAME_CSUM_EN
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'h88) begin
            errors++;
            $display("[TB] FAIL eoi_csum: got %b/%0h expected 1/88", seen, sd);
        end
`endif
        checks++;
        if (overrun !== 1'b1 || sts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: got overrun=%b sts_valid=%b expected 1/0", overrun, sts_valid);
        end
    endtask

    task automatic test_reset_mid();
        int          c;
        logic        seen;
        logic [7:0]  sd;
        logic [12:0] got;
        logic [7:0]  sum = 8'h00;
        send_rx(8'hA5, c);
        send_rx(8'h01, c);
        for (int i = 0; i < 5; i++)
            send_rx(8'h40 + 8'(i), c);
        rst_n = 1'b0;
        #1;
        got = {px_valid, px_data, sts_valid, busy, overrun, |sts_data};
        checks++;
        if (got !== 13'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_outputs: got %0h expected 0", got);
        end
        tick(1);
        rst_n = 1'b1;
        px_q.delete();
        pxc_q.delete();
        send_rx(8'hA5, c);
        send_rx(8'h01, c);
        for (int i = 0; i < 16; i++) begin
            send_rx(8'h90 + 8'(i), c);
            sum = sum + 8'h90 + 8'(i);
        end
        tick(2);
        checks++;
        if (px_q.size() != 16 || busy !== 1'b1 || overrun !== 1'b0 || sts_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_reload: got px=%0d busy=%b overrun=%b sts_valid=%b expected 16/1/0/0",
                     px_q.size(), busy, overrun, sts_valid);
        end
        send_enc(8'hFF);
        send_enc(8'hD9);
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_mid_status: got %b/%0h expected 1/0", seen, sd);
        end
`ifdef FRAME_CSUM_EN
        take_status(seen, sd);
        checks++;
        if (!seen || sd !== sum) begin
            errors++;
            $display("[TB] FAIL reset_mid_csum: got %b/%0h expected 1/%0h", seen, sd, sum);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(3);
        test_reset();
        rst_n = 1'b1;
        tick(2);
        test_frame();
        tick(2);
        test_pad();
        tick(2);
        test_ping();
        tick(2);
        test_eoi_overrun();
        tick(2);
        test_reset_mid();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
